// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the register-file write-back arbiter slice.
//   reg_idx_t  : 5-bit architectural register index
//   REG_X0     : hard-wired zero register; writes to it are never committed
//   wb_src_t   : identifies a write-back producer (ALU or load unit)
//   wb_req_t   : one write-back payload (destination index + data)
//   raw_hit()  : read-after-write match of a read index against a write source
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int WB_D_WIDTH = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_t;

    typedef struct packed {
        reg_idx_t                rd;
        logic [WB_D_WIDTH-1:0]   dat;
    } wb_req_t;

    // A read of x0 never depends on an in-flight write, so it is excluded here.
    function automatic logic raw_hit(input reg_idx_t rs,
                                     input logic     wr_valid,
                                     input reg_idx_t wr_rd);
        return (rs != REG_X0) && wr_valid && (wr_rd == rs);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the write-back producer handshakes, the register-file write port,
// the decode read-index / busy-flag pair and the commit counter.
//   slave  modport : the arbiter (consumes requests, drives ready/write port)
//   master modport : the surrounding pipeline (producers, decode, register file)
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_dat : ALU write-back request
//   ld_valid/ld_ready/ld_rd/ld_dat     : load-unit write-back request
//   regStr/rd/WBDat                    : registered register-file write port
//   rs1/rs2, rs1_busy/rs2_busy         : decode read indices and RAW flags
//   wb_cnt                             : committed register writes
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = 32
) ();

    logic               alu_valid;
    logic               alu_ready;
    reg_idx_t           alu_rd;
    logic [D_WIDTH-1:0] alu_dat;

    logic               ld_valid;
    logic               ld_ready;
    reg_idx_t           ld_rd;
    logic [D_WIDTH-1:0] ld_dat;

    logic               regStr;
    reg_idx_t           rd;
    logic [D_WIDTH-1:0] WBDat;

    reg_idx_t           rs1;
    reg_idx_t           rs2;
    logic               rs1_busy;
    logic               rs2_busy;

    logic [31:0]        wb_cnt;

    modport slave (
        input  alu_valid, alu_rd, alu_dat,
        input  ld_valid,  ld_rd,  ld_dat,
        input  rs1, rs2,
        output alu_ready, ld_ready,
        output regStr, rd, WBDat,
        output rs1_busy, rs2_busy,
        output wb_cnt
    );

    modport master (
        output alu_valid, alu_rd, alu_dat,
        output ld_valid,  ld_rd,  ld_dat,
        output rs1, rs2,
        input  alu_ready, ld_ready,
        input  regStr, rd, WBDat,
        input  rs1_busy, rs2_busy,
        input  wb_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Bit 0 is the ALU, bit 1 the load unit.
// A lone requester is always granted; on a tie the requester that did not
// win the previous transfer is granted. The pointer moves only when the
// caller signals that the grant was actually used (advance).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector {ld, alu}
//   advance    : a transfer happened this cycle with the current grant
//   gnt[1:0]   : one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    wb_src_t last_grant_q;
    wb_src_t last_grant_d;

    // Grant decode: purely a function of the requests and the pointer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == WB_LD) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = gnt[1] ? WB_LD : WB_ALU;
        end
    end

    // Resetting to LD hands the first tie after reset to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state flops update with non-blocking assignments so every flop samples pre-edge values.
            last_grant_q <= WB_LD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU result path
// and the load unit. The winning request is registered into regStr/rd/WBDat
// one cycle after its handshake, so the port sustains one write per cycle.
// Writes to x0 are accepted but never strobed or counted. Combinational
// busy flags tell decode whether rs1/rs2 still have a write in flight,
// either still requesting or sitting in the output stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wb_arbiter_if.slave (see interface header)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    logic [1:0]         req;
    logic [1:0]         gnt;
    logic               alu_ready;
    logic               ld_ready;
    logic               xfer;

    reg_idx_t           sel_rd;
    logic [D_WIDTH-1:0] sel_dat;

    logic               reg_str_q, reg_str_d;
    reg_idx_t           rd_q,      rd_d;
    logic [D_WIDTH-1:0] wb_dat_q,  wb_dat_d;
    logic [31:0]        wb_cnt_q,  wb_cnt_d;

    assign req = {bus.ld_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt)
    );

    // Readies are masked by rst_n so no handshake can complete while the
    // block is held in reset, even though requesters keep valid asserted.
    assign alu_ready = gnt[0] & rst_n;
    assign ld_ready  = gnt[1] & rst_n;
    assign xfer      = alu_ready | ld_ready;

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = ld_ready;

    // Output stage: capture the accepted payload, strobe unless it targets x0.
    always_comb begin
        sel_rd    = ld_ready ? bus.ld_rd  : bus.alu_rd;
        sel_dat   = ld_ready ? bus.ld_dat : bus.alu_dat;

        reg_str_d = xfer && (sel_rd != REG_X0);
        rd_d      = xfer ? sel_rd  : rd_q;
        wb_dat_d  = xfer ? sel_dat : wb_dat_q;

        // Counts at the edge that commits the write; wraps naturally at 2^32.
        wb_cnt_d  = wb_cnt_q + 32'(reg_str_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only the small output-stage state is reset; the register file itself lives elsewhere.
            reg_str_q <= 1'b0;
            rd_q      <= REG_X0;
            wb_dat_q  <= '0;
            wb_cnt_q  <= '0;
        end else begin
            reg_str_q <= reg_str_d;
            rd_q      <= rd_d;
            wb_dat_q  <= wb_dat_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

    assign bus.regStr = reg_str_q;
    assign bus.rd     = rd_q;
    assign bus.WBDat  = wb_dat_q;
    assign bus.wb_cnt = wb_cnt_q;

    // The output-stage term covers the cycle before the register file commits.
    assign bus.rs1_busy = raw_hit(bus.rs1, bus.alu_valid, bus.alu_rd)
                        | raw_hit(bus.rs1, bus.ld_valid,  bus.ld_rd)
                        | raw_hit(bus.rs1, reg_str_q,     rd_q);

    assign bus.rs2_busy = raw_hit(bus.rs2, bus.alu_valid, bus.alu_rd)
                        | raw_hit(bus.rs2, bus.ld_valid,  bus.ld_rd)
                        | raw_hit(bus.rs2, reg_str_q,     rd_q);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed stimulus against regfile_wb_arbiter. A behavioural model tracks
// who won last, the write waiting to commit and the commit count; a compare
// process checks every DUT output against it on each falling clock edge.
// Literal expectations in the stimulus pin the model to hand-worked values.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int D_WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.D_WIDTH(D_WIDTH)) bus ();

    regfile_wb_arbiter #(.D_WIDTH(D_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    wb_src_t     m_last  = WB_LD;   // producer that won the last transfer
    logic        m_str   = 1'b0;    // a real write waits in the output stage
    wb_req_t     m_out   = '0;      // payload most recently accepted
    logic [31:0] m_cnt   = '0;      // commits observed since reset
    logic [31:0] cnt_adj = '0;      // offset applied when the counter is preloaded
    logic [1:0]  m_gnt;             // {ld, alu} expected accept this cycle

    always_comb begin
        m_gnt = 2'b00;
        if (rst_n === 1'b1) begin
            if (bus.alu_valid && bus.ld_valid)
                m_gnt = (m_last == WB_LD) ? 2'b01 : 2'b10;
            else
                m_gnt = {bus.ld_valid, bus.alu_valid};
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= WB_LD;
            m_str  <= 1'b0;
            m_out  <= '0;
            m_cnt  <= '0;
        end else begin
            m_cnt <= m_cnt + 32'(m_str);
            if (m_gnt[1]) begin
                m_last <= WB_LD;
                m_out  <= '{rd: bus.ld_rd, dat: bus.ld_dat};
                m_str  <= (bus.ld_rd != REG_X0);
            end else if (m_gnt[0]) begin
                m_last <= WB_ALU;
                m_out  <= '{rd: bus.alu_rd, dat: bus.alu_dat};
                m_str  <= (bus.alu_rd != REG_X0);
            end else begin
                m_str  <= 1'b0;
            end
        end
    end

    function automatic logic exp_busy(input reg_idx_t rs);
        if (rs == REG_X0) return 1'b0;
        return (bus.alu_valid && bus.alu_rd == rs) ||
               (bus.ld_valid  && bus.ld_rd  == rs) ||
               (m_str         && m_out.rd   == rs);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cmp alu_ready", 32'(bus.alu_ready), 32'(m_gnt[0]));
        check("cmp ld_ready",  32'(bus.ld_ready),  32'(m_gnt[1]));
        check("cmp regStr",    32'(bus.regStr),    32'(m_str));
        check("cmp rd",        32'(bus.rd),        32'(m_out.rd));
        check("cmp WBDat",     bus.WBDat,          m_out.dat);
        check("cmp wb_cnt",    bus.wb_cnt,         m_cnt + cnt_adj);
        check("cmp rs1_busy",  32'(bus.rs1_busy),  32'(exp_busy(bus.rs1)));
        check("cmp rs2_busy",  32'(bus.rs2_busy),  32'(exp_busy(bus.rs2)));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, limit 50000", $time);
        $fatal(1);
    end

    initial begin
        int a_idx;
        int l_idx;

        rst_n         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_dat   = 32'hDEAD_BEEF;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = 5'd0;
        bus.ld_dat    = '0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;

        // Reset state, with an ALU request already waiting.
        tick(); tick(); #3;
        check("reset regStr",    32'(bus.regStr),    0);
        check("reset rd",        32'(bus.rd),        0);
        check("reset WBDat",     bus.WBDat,          0);
        check("reset wb_cnt",    bus.wb_cnt,         0);
        check("reset alu_ready", 32'(bus.alu_ready), 0);

        // Single ALU write: accept at cycle 0, strobe at 1, count at 2.
        tick(); rst_n = 1'b1; #3;
        check("t1 alu_ready", 32'(bus.alu_ready), 1);
        check("t1 ld_ready",  32'(bus.ld_ready),  0);
        tick(); bus.alu_valid = 1'b0; #3;
        check("t1 regStr", 32'(bus.regStr), 1);
        check("t1 rd",     32'(bus.rd),     5);
        check("t1 WBDat",  bus.WBDat,       32'hDEAD_BEEF);
        check("t1 cnt0",   bus.wb_cnt,      0);
        tick(); #3;
        check("t1 cnt1",      bus.wb_cnt,      1);
        check("t1 regStr lo", 32'(bus.regStr), 0);
        check("t1 rd hold",   32'(bus.rd),     5);

        // Load to x0: accepted, never strobed or counted.
        tick(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_dat = 32'h1234; #3;
        check("x0 ld_ready", 32'(bus.ld_ready), 1);
        tick(); bus.ld_valid = 1'b0; #3;
        check("x0 regStr", 32'(bus.regStr), 0);
        check("x0 WBDat",  bus.WBDat,       32'h1234);
        tick(); #3;
        check("x0 wb_cnt", bus.wb_cnt, 1);

        // Both valid for 4 cycles: ALU, LD, ALU, LD with no bubbles.
        a_idx = 1;
        l_idx = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(a_idx);
            bus.alu_dat   = 32'hA000 + 32'(a_idx);
            bus.ld_valid  = 1'b1;
            bus.ld_rd     = 5'd9;
            bus.ld_dat    = 32'hB000 + 32'(l_idx);
            #3;
            check("rr alu_ready", 32'(bus.alu_ready), (k % 2 == 0) ? 1 : 0);
            check("rr ld_ready",  32'(bus.ld_ready),  (k % 2 == 1) ? 1 : 0);
            if (k > 0) check("rr regStr", 32'(bus.regStr), 1);
            if (bus.alu_ready) a_idx++;
            if (bus.ld_ready)  l_idx++;
        end
        tick(); bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; #3;
        check("rr last regStr", 32'(bus.regStr), 1);
        check("rr last rd",     32'(bus.rd),     9);
        check("rr last WBDat",  bus.WBDat,       32'hB001);
        check("rr wb_cnt",      bus.wb_cnt,      4);
        tick(); #3;
        check("rr wb_cnt end",  bus.wb_cnt,      5);

        // Busy flags across pending, output stage and commit.
        tick(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_dat = 32'h77;
        bus.rs1 = 5'd7; bus.rs2 = 5'd0; #3;
        check("busy pend rs1", 32'(bus.rs1_busy), 1);
        check("busy pend rs2", 32'(bus.rs2_busy), 0);
        tick(); bus.ld_valid = 1'b0; #3;
        check("busy wb rs1", 32'(bus.rs1_busy), 1);
        check("busy wb rs2", 32'(bus.rs2_busy), 0);
        tick(); #3;
        check("busy done rs1", 32'(bus.rs1_busy), 0);

        // Same rd from both: ALU wins the tie, LD commits later and wins.
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_dat = 32'h11;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd6; bus.ld_dat  = 32'h22;
        bus.rs2 = 5'd6; #3;
        check("same alu_ready", 32'(bus.alu_ready), 1);
        check("same rs2_busy",  32'(bus.rs2_busy),  1);
        tick(); bus.alu_valid = 1'b0; #3;
        check("same ld_ready", 32'(bus.ld_ready), 1);
        check("same WBDat1",   bus.WBDat,         32'h11);
        tick(); bus.ld_valid = 1'b0; #3;
        check("same WBDat2",   bus.WBDat,         32'h22);
        check("same rd",       32'(bus.rd),       6);
        tick(); #3;
        check("same rs2 idle", 32'(bus.rs2_busy), 0);

        // Counter wrap from a preloaded value.
        tick();
        force dut.wb_cnt_q = 32'hFFFF_FFFF;
        cnt_adj = 32'hFFFF_FFFF - m_cnt;
        #1;
        release dut.wb_cnt_q;
        #1;
        check("wrap preload", bus.wb_cnt, 32'hFFFF_FFFF);
        tick(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_dat = 32'h33; #3;
        check("wrap alu_ready", 32'(bus.alu_ready), 1);
        tick(); bus.alu_valid = 1'b0; #3;
        check("wrap regStr", 32'(bus.regStr), 1);
        tick(); #3;
        check("wrap wb_cnt", bus.wb_cnt,      0);
        check("wrap rd",     32'(bus.rd),     3);

        // Reset while a write sits in the output stage.
        tick(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_dat = 32'hC; #3;
        check("rst accept", 32'(bus.alu_ready), 1);
        tick();
        bus.alu_rd = 5'd13; bus.alu_dat = 32'hD;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd14; bus.ld_dat = 32'hE;
        #1;
        rst_n   = 1'b0;
        cnt_adj = '0;
        #1;
        check("rst regStr",    32'(bus.regStr),    0);
        check("rst rd",        32'(bus.rd),        0);
        check("rst WBDat",     bus.WBDat,          0);
        check("rst alu_ready", 32'(bus.alu_ready), 0);
        check("rst ld_ready",  32'(bus.ld_ready),  0);
        tick(); #3;
        check("rst hold regStr", 32'(bus.regStr), 0);
        tick(); rst_n = 1'b1; #3;
        check("rst regrant alu", 32'(bus.alu_ready), 1);
        check("rst regrant ld",  32'(bus.ld_ready),  0);
        tick(); bus.alu_valid = 1'b0; #3;
        check("rst ld next", 32'(bus.ld_ready), 1);
        check("rst rd13",    32'(bus.rd),       13);
        check("rst WBDat13", bus.WBDat,         32'hD);
        tick(); bus.ld_valid = 1'b0; #3;
        check("rst rd14",    32'(bus.rd),       14);
        check("rst cnt1",    bus.wb_cnt,        1);
        tick(); #3;
        check("rst cnt2",    bus.wb_cnt,        2);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write-back port between two producers: the ALU result path and the load unit. Arbitration is round-robin with valid/ready handshakes. The block registers the winning write into the register file's regStr/rd/WBDat inputs. It also supplies read-after-write busy flags for the rs1/rs2 read ports, which the decode stall logic consumes.

Parameters:
- D_WIDTH, 32, data width of the write-back payload and the register file.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_dat  in  D_WIDTH  ALU result.
- ld_valid  in  1  load write-back request.
- ld_ready  out  1  load request accepted this cycle.
- ld_rd  in  5  load destination register.
- ld_dat  in  D_WIDTH  load data.
- regStr  out  1  register-file write strobe (registered).
- rd  out  5  register-file write index (registered).
- WBDat  out  D_WIDTH  register-file write data (registered).
- rs1  in  5  read-port 1 index from decode.
- rs2  in  5  read-port 2 index from decode.
- rs1_busy  out  1  rs1 has an uncommitted pending write (combinational).
- rs2_busy  out  1  rs2 has an uncommitted pending write (combinational).
- wb_cnt  out  32  count of committed register writes.

Behaviour:
- Reset values:
  - regStr, rd, WBDat and wb_cnt are 0.
  - last_grant resets to LD, so the ALU wins the first tie.
  - alu_ready and ld_ready are 0 while rst_n is low.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - A requester holds valid, rd and dat stable until accepted. It must not wait for ready before raising valid.
  - ready depends combinationally on both valids. No combinational path exists from ready back to valid.
- Arbitration:
  - At most one ready is high per cycle, and ready is only asserted to a valid requester.
  - Only one valid: that requester is granted regardless of last_grant.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant updates on every transfer to the granted requester.
  - Neither valid: no grant, and last_grant holds.
- Output stage (1-cycle latency):
  - The cycle after a transfer, rd and WBDat carry the accepted payload.
  - regStr = 1 in that cycle, unless the accepted rd is 0.
  - With no transfer, regStr = 0 and rd/WBDat hold their last values.
  - Back-to-back transfers give regStr high on consecutive cycles. There are no bubbles: the port sustains one write per cycle.
- x0 rule: a request with rd = 0 is still accepted (ready asserted, arbitration pointer advances). regStr stays 0 and wb_cnt does not increment.
- Busy flags, for N in {1, 2}:
  - rsN_busy = (rsN != 0) && ((alu_valid && alu_rd == rsN) || (ld_valid && ld_rd == rsN) || (regStr && rd == rsN)).
  - The output-stage term is required because the register file commits on the edge ending the regStr cycle.
- wb_cnt increments by 1 on every cycle where regStr = 1. It wraps from 0xFFFFFFFF to 0 silently.
- Same rd from both requesters in one cycle: only the granted write proceeds. The other waits and commits later, so the later-granted value wins in the register file.
- Reset mid-operation:
  - Outputs clear immediately. Any write sitting in the output stage is dropped; no regStr is issued for it.
  - A pending requester keeps valid asserted.
  - After rst_n deasserts, arbitration restarts with ALU priority on a tie.

Decomposition:
- Package regfile_pkg:
  - typedef reg_idx_t (logic [4:0]).
  - constant REG_X0 = 5'd0.
  - enum wb_src_t {WB_ALU, WB_LD}.
  - struct wb_req_t {reg_idx_t rd; logic [D_WIDTH-1:0] dat}.
- Sub-module rr_arb2: 2-way round-robin arbiter. It takes req[1:0] and an advance strobe, and outputs a one-hot gnt[1:0]. It holds the last_grant flop internally. The top level owns the output stage, the busy logic and wb_cnt.

Test Plan:
- Reset release, then alu_valid=1, alu_rd=5, alu_dat=0xDEADBEEF -> alu_ready=1 at cycle 0; at cycle 1, regStr=1, rd=5, WBDat=0xDEADBEEF; wb_cnt=1 at cycle 2.
- Both valid every cycle for 4 cycles, with ALU rd=1..4 and LD rd=9 held -> grants go ALU, LD, ALU, LD; exactly one ready per cycle; regStr stays high for 4 consecutive cycles.
- ld_valid with ld_rd=0, ld_dat=0x1234 -> ld_ready=1; next cycle regStr=0; wb_cnt unchanged.
- ld_valid with ld_rd=7, decode presents rs1=7, rs2=0 -> rs1_busy=1 and rs2_busy=0 while pending, and during the regStr cycle; rs1_busy=0 the cycle after.
- Force wb_cnt to 0xFFFFFFFF via one committed write from a preloaded state -> wb_cnt wraps to 0 with no other side effects.
- Assert rst_n low in the cycle after an accepted write (regStr=1) -> regStr, rd and WBDat read 0 immediately; the held ALU request is re-granted after reset release.
